// File: rtl/dev_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dev_timer : bus-mapped countdown timer with masked interrupt  (rev 1.0)  |
// +--------------------------------------------------------------------------+
module dev_timer #(
  parameter logic [31:0] BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] DEV_Addr,
  input  logic [31:0] DEV_WD,
  input  logic        DEV_Wr,
  input  logic        IntAck,
  output logic [31:0] DEV_RD,
  output logic        IntReq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  state_t      state;
  logic [3:0]  ctrl;
  logic [3:0]  ctrl_nxt;
  logic [31:0] preset;
  logic [31:0] count;
  logic        pending;
  logic        pending_nxt;
  logic [31:0] word_addr;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        wr_status;
  logic        auto_reload;
  logic        unused_addr_lsbs;

  assign word_addr        = {DEV_Addr[31:2], 2'b00};
  assign unused_addr_lsbs = ^DEV_Addr[1:0];
  assign wr_ctrl          = DEV_Wr && (word_addr == BASE);
  assign wr_preset        = DEV_Wr && (word_addr == BASE + 32'h4);
  assign wr_status        = DEV_Wr && (word_addr == BASE + 32'hC);
  assign auto_reload      = (ctrl[2:1] == 2'b01);

  // A CPU write to CTRL in the INT cycle overrides the one-shot EN clear.
  always_comb begin
    ctrl_nxt = ctrl;
    if (wr_ctrl)
      ctrl_nxt = DEV_WD[3:0];
    else if (state == ST_INT && !auto_reload)
      ctrl_nxt[0] = 1'b0;
  end

  always_comb begin
    pending_nxt = pending;
    if (IntAck || (wr_status && DEV_WD[0]))
      pending_nxt = 1'b0;
    if (state == ST_INT)
      pending_nxt = 1'b1;
  end

  always_comb begin
    DEV_RD = 32'h0;
    if (word_addr == BASE)
      DEV_RD = {28'h0, ctrl};
    else if (word_addr == BASE + 32'h4)
      DEV_RD = preset;
    else if (word_addr == BASE + 32'h8)
      DEV_RD = count;
    else if (word_addr == BASE + 32'hC)
      DEV_RD = {31'h0, pending};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      ctrl    <= 4'h0;
      preset  <= 32'h0;
      count   <= 32'h0;
      pending <= 1'b0;
      IntReq  <= 1'b0;
    end else begin
      ctrl    <= ctrl_nxt;
      pending <= pending_nxt;
      // Built from next-state values so IntReq rises together with pending.
      IntReq  <= pending_nxt & ctrl_nxt[3];
      if (wr_preset)
        preset <= DEV_WD;
      case (state)
        ST_IDLE: if (ctrl[0]) state <= ST_LOAD;
        ST_LOAD: begin
          count <= preset;
          state <= ST_CNT;
        end
        ST_CNT: begin
          if (!ctrl[0]) begin
            state <= ST_IDLE;
          end else if (count <= 32'd1) begin
            count <= 32'h0;
            state <= ST_INT;
          end else begin
            count <= count - 32'd1;
          end
        end
        ST_INT:  state <= (auto_reload && ctrl_nxt[0]) ? ST_LOAD : ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dev_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dev_timer : randomized self-checking bench for dev_timer   (rev 1.0)  |
// +--------------------------------------------------------------------------+
module tb_dev_timer;

  localparam logic [31:0] BASE     = 32'h0000_7F00;
  localparam logic [31:0] A_CTRL   = BASE;
  localparam logic [31:0] A_PRESET = BASE + 32'h4;
  localparam logic [31:0] A_COUNT  = BASE + 32'h8;
  localparam logic [31:0] A_STATUS = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] DEV_Addr = 32'h0;
  logic [31:0] DEV_WD = 32'h0;
  logic        DEV_Wr = 1'b0;
  logic        IntAck = 1'b0;
  logic [31:0] DEV_RD;
  logic        IntReq;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  dev_timer #(.BASE(BASE)) dut (
    .clk(clk), .reset(reset), .DEV_Addr(DEV_Addr), .DEV_WD(DEV_WD),
    .DEV_Wr(DEV_Wr), .IntAck(IntAck), .DEV_RD(DEV_RD), .IntReq(IntReq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    DEV_Addr = a; DEV_WD = d; DEV_Wr = 1'b1;
    @(posedge clk); #1;
    DEV_Wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    DEV_Addr = a; #1; d = DEV_RD;
  endtask

  task automatic ack();
    IntAck = 1'b1; step(1); IntAck = 1'b0;
  endtask

  // Returns the cycle stamp of the first edge after which IntReq is high, -1 on timeout.
  task automatic wait_irq(input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      step(1);
      if (IntReq === 1'b1) begin at = cyc; break; end
    end
  endtask

  task automatic cleanup();
    bus_write(A_CTRL, 32'h0); step(3); bus_write(A_STATUS, 32'h1); step(1);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1; step(2); reset = 1'b0; step(1);
    for (int i = 0; i < 4; i++) begin
      bus_read(BASE + 32'(4 * i), d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_reg%0d: got %h want %h", i, d, 32'h0); end
    end
    checks++; if (IntReq !== 1'b0) begin errors++; $display("FAIL reset_intreq: got %b want 0", IntReq); end
    bus_write(A_COUNT, 32'h55); bus_read(A_COUNT, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL count_ro: got %h want %h", d, 32'h0); end
    bus_write(BASE + 32'h10, 32'hFFFF_FFFF); bus_write(BASE + 32'h20, 32'hF); bus_write(32'h0000_8000, 32'hF);
    bus_read(BASE + 32'h10, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reserved_read: got %h want %h", d, 32'h0); end
    bus_read(A_CTRL, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL stray_write_ctrl: got %h want %h", d, 32'h0); end
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    int e0, at;
    bus_write(A_PRESET, 32'd5); bus_write(A_CTRL, 32'h9); e0 = cyc;
    wait_irq(30, at);
    checks++; if (at - e0 !== 8) begin errors++; $display("FAIL oneshot_latency: got %0d want %0d", at - e0, 8); end
    bus_read(A_COUNT, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL oneshot_count: got %h want %h", d, 32'h0); end
    bus_read(A_CTRL, d);
    checks++; if (d !== 32'h8) begin errors++; $display("FAIL oneshot_ctrl: got %h want %h", d, 32'h8); end
    bus_read(A_STATUS, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL oneshot_status: got %h want %h", d, 32'h1); end
    ack();
    checks++; if (IntReq !== 1'b0) begin errors++; $display("FAIL oneshot_ack: got %b want 0", IntReq); end
    bus_read(A_STATUS, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL oneshot_ack_status: got %h want %h", d, 32'h0); end
  endtask

  task automatic test_autoreload();
    logic [31:0] d;
    int e0, at, prev;
    bus_write(A_PRESET, 32'd3); bus_write(A_CTRL, 32'hB); e0 = cyc;
    wait_irq(30, at);
    checks++; if (at - e0 !== 6) begin errors++; $display("FAIL auto_first: got %0d want %0d", at - e0, 6); end
    for (int r = 0; r < 2; r++) begin
      prev = at;
      if (r == 1) begin
        bus_write(A_STATUS, 32'h0); bus_read(A_STATUS, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL status_write0: got %h want %h", d, 32'h1); end
      end
      bus_write(A_STATUS, 32'h1);
      checks++; if (IntReq !== 1'b0) begin errors++; $display("FAIL auto_clear%0d: got %b want 0", r, IntReq); end
      wait_irq(30, at);
      checks++; if (at - prev !== 5) begin errors++; $display("FAIL auto_period%0d: got %0d want %0d", r, at - prev, 5); end
    end
    cleanup();
  endtask

  task automatic test_stop();
    logic [31:0] d;
    logic seen;
    bus_write(A_PRESET, 32'd10); bus_write(A_CTRL, 32'h9);
    step(4); bus_write(A_CTRL, 32'h8);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin step(1); if (IntReq === 1'b1) seen = 1'b1; end
    bus_read(A_COUNT, d);
    checks++; if (d !== 32'd7) begin errors++; $display("FAIL stop_freeze: got %0d want %0d", d, 7); end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL stop_no_irq: got %b want 0", seen); end
    bus_write(A_CTRL, 32'h9); step(2); bus_read(A_COUNT, d);
    checks++; if (d !== 32'd10) begin errors++; $display("FAIL stop_reload: got %0d want %0d", d, 10); end
    bus_write(A_CTRL, 32'h9); step(1); bus_read(A_COUNT, d);
    checks++; if (d !== 32'd8) begin errors++; $display("FAIL en_no_restart: got %0d want %0d", d, 8); end
    bus_write(A_PRESET, 32'd3); step(1); bus_read(A_COUNT, d);
    checks++; if (d !== 32'd6) begin errors++; $display("FAIL preset_no_disturb: got %0d want %0d", d, 6); end
    cleanup();
  endtask

  task automatic test_small_preset();
    logic [31:0] d;
    logic seen;
    int e0, at;
    for (int n = 0; n < 2; n++) begin
      bus_write(A_PRESET, 32'(n)); bus_write(A_CTRL, 32'h9); e0 = cyc;
      wait_irq(20, at);
      checks++; if (at - e0 !== 4) begin errors++; $display("FAIL small_n%0d_latency: got %0d want %0d", n, at - e0, 4); end
      ack();
      bus_write(A_CTRL, 32'h1);
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin step(1); if (IntReq === 1'b1) seen = 1'b1; end
      bus_read(A_STATUS, d);
      checks++; if (d !== 32'h1) begin errors++; $display("FAIL masked_n%0d_pending: got %h want %h", n, d, 32'h1); end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL masked_n%0d_intreq: got %b want 0", n, seen); end
      bus_write(A_CTRL, 32'h8);
      checks++; if (IntReq !== 1'b1) begin errors++; $display("FAIL unmask_n%0d: got %b want 1", n, IntReq); end
      bus_write(A_CTRL, 32'h0); bus_read(A_STATUS, d);
      checks++; if (IntReq !== 1'b0 || d !== 32'h1) begin errors++; $display("FAIL remask_n%0d: got intreq=%b status=%h want intreq=0 status=1", n, IntReq, d); end
      bus_write(A_STATUS, 32'h1);
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] d;
    bus_write(A_PRESET, 32'd5); bus_write(A_CTRL, 32'h9);
    step(7);
    // Edge that processes INT: ack and an EN=1 CTRL write land together.
    DEV_Addr = A_CTRL; DEV_WD = 32'h9; DEV_Wr = 1'b1; IntAck = 1'b1;
    step(1);
    DEV_Wr = 1'b0; IntAck = 1'b0;
    checks++; if (IntReq !== 1'b1) begin errors++; $display("FAIL set_wins: got %b want 1", IntReq); end
    bus_read(A_CTRL, d);
    checks++; if (d !== 32'h9) begin errors++; $display("FAIL cpu_ctrl_wins: got %h want %h", d, 32'h9); end
    ack(); step(6);
    bus_write(A_CTRL, 32'h8);
    checks++; if (IntReq !== 1'b1) begin errors++; $display("FAIL stop_in_int_pending: got %b want 1", IntReq); end
    step(3); bus_read(A_COUNT, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL stop_in_int_idle: got %0d want %0d", d, 0); end
    ack(); cleanup();
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [1:0]  m;
    int n, k, e0, at, prev, lat, per;
    for (int it = 0; it < 8; it++) begin
      n   = int'($urandom_range(0, 9));
      m   = 2'($urandom_range(0, 3));
      lat = (n == 0) ? 4 : n + 3;
      per = (n == 0) ? 3 : n + 2;
      bus_write(A_PRESET, 32'(n)); bus_write(A_CTRL, {28'h0, 1'b1, m, 1'b1}); e0 = cyc;
      if (n >= 2) begin
        k = int'($urandom_range(2, n + 1));
        step(k); bus_read(A_COUNT, d);
        checks++; if (d !== 32'(n - (k - 2))) begin errors++; $display("FAIL rand%0d_count: got %0d want %0d", it, d, n - (k - 2)); end
      end
      wait_irq(40, at);
      checks++; if (at - e0 !== lat) begin errors++; $display("FAIL rand%0d_latency: got %0d want %0d", it, at - e0, lat); end
      if (m == 2'b01) begin
        prev = at; ack(); wait_irq(40, at);
        checks++; if (at - prev !== per) begin errors++; $display("FAIL rand%0d_period: got %0d want %0d", it, at - prev, per); end
      end else begin
        bus_read(A_CTRL, d);
        checks++; if (d !== {28'h0, 1'b1, m, 1'b0}) begin errors++; $display("FAIL rand%0d_ctrl: got %h want %h", it, d, {28'h0, 1'b1, m, 1'b0}); end
      end
      cleanup();
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic seen;
    bus_write(A_PRESET, 32'd20); bus_write(A_CTRL, 32'h9); step(6);
    @(negedge clk); reset = 1'b1; #1;
    checks++; if (IntReq !== 1'b0) begin errors++; $display("FAIL midreset_intreq: got %b want 0", IntReq); end
    for (int i = 0; i < 4; i++) begin
      bus_read(BASE + 32'(4 * i), d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL midreset_reg%0d: got %h want %h", i, d, 32'h0); end
    end
    step(2); reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin step(1); if (IntReq === 1'b1) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midreset_quiet: got %b want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_autoreload();
    test_stop();
    test_small_preset();
    test_simultaneous();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dev_timer.md
# dev_timer

Memory-mapped programmable timer on the CPU device bus, window 0x0000_7F00–0x0000_7F20. It decodes the device write strobe and the store address/data that the multi-cycle controller issues in its memory state, and returns read data for device loads. It counts down from a preset and raises the `IntReq` interrupt line that the controller samples before fetch. It is the responder side of the controller's DEV_Wr / IntReq interface.

## Interface
- `BASE`, 32'h0000_7F00, base address of the register window.
- `clk` input 1, system clock; all state updates on the rising edge.
- `reset` input 1, asynchronous, active-high; clears all state.
- `DEV_Addr` input 32, byte address from the ALU output (`ALUOut_DEV`).
- `DEV_WD` input 32, store data.
- `DEV_Wr` input 1, device write strobe, one cycle wide.
- `IntAck` input 1, one-cycle pulse when the CPU enters the exception state (`IntReq_out`).
- `DEV_RD` output 32, combinational read data for `DEV_Addr`.
- `IntReq` output 1, registered interrupt request, `pending & CTRL.IM`.

## Operation
- Register map, word-aligned; `DEV_Addr[1:0]` ignored:
  - BASE+0x0 CTRL, R/W. Bit0 EN, bits[2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), bit3 IM. Bits[31:4] read 0 and ignore writes.
  - BASE+0x4 PRESET, R/W, 32 bit.
  - BASE+0x8 COUNT, read-only; writes ignored.
  - BASE+0xC STATUS, bit0 = pending. Writing a 1 to bit0 clears pending; writing 0 has no effect.
  - BASE+0x10..0x20: reads return 0, writes ignored. Addresses outside the window: `DEV_RD` = 0, writes ignored.
- FSM states and transitions:
  - IDLE: if EN=1, go to LOAD.
  - LOAD: COUNT <= PRESET, go to CNT.
  - CNT: if EN=0, go to IDLE with COUNT held. Else if COUNT ≤ 1, COUNT <= 0 and go to INT. Else COUNT <= COUNT−1.
  - INT: pending <= 1. In MODE 00, clear EN and go to IDLE. In MODE 01, go to LOAD.
- Unsigned arithmetic throughout; COUNT never underflows below 0.
- A PRESET write does not disturb the running COUNT. It takes effect at the next LOAD.
- Writing CTRL with EN=0 stops the count at the next edge. Writing EN=1 while counting causes no restart.
- Reset values: state IDLE; CTRL, PRESET, COUNT and pending all 0; `IntReq` 0. `DEV_RD` is 0 for every in-window address.
- `reset` asserted mid-count returns the block to reset values immediately. No interrupt is raised afterwards.

## Timing
- Register writes land on the rising edge where `DEV_Wr`=1 and the address hits.
- Latency, with E0 the edge that writes EN=1 and PRESET=N:
  - E1: LOAD.
  - E2: CNT, with COUNT=N.
  - For N ≥ 1: INT at E(N+2); pending and `IntReq` high at E(N+3).
  - For N=0: INT at E3; `IntReq` high at E4.
- Auto-reload period: INT recurs every N+2 cycles for N ≥ 1.
- `IntReq` stays high until pending is cleared by an `IntAck` pulse, by a STATUS write of 1, or by IM being cleared. Clearing IM masks the output only; pending is kept.
- Simultaneous events:
  - Set and clear of pending on the same edge: set wins.
  - CPU CTRL write in the INT cycle: the CPU value wins over the automatic EN clear.
  - CPU write to EN=0 while in INT: pending is still set, then the FSM goes to IDLE.

## Test plan
- Reset, then read all of 0x7F00–0x7F0C: all return 0 and `IntReq`=0. Write COUNT=0x55, read it back: 0.
- PRESET=5, CTRL=0x9 (EN, one-shot, IM): `IntReq` rises exactly 8 edges after the CTRL write. COUNT reads 0, CTRL reads 0x8. The `IntReq` pulse on `IntAck` drops on the next edge.
- PRESET=3, CTRL=0xB (auto-reload): pending set every 5 cycles. Clear via STATUS write 0x1 between events; the next event re-raises `IntReq`.
- PRESET=10, CTRL=0x9, then write CTRL=0x8 after 4 cycles: COUNT freezes at its current value (7) and no `IntReq` follows. Re-enable: the count reloads 10.
- PRESET=0 and PRESET=1, one-shot: both raise `IntReq` 4 edges after the enable write. Same run with IM=0: pending=1 in STATUS, `IntReq` stays 0.
- Assert `reset` mid-count with PRESET=20: all outputs 0 immediately, and `IntReq` stays 0 for 30 further cycles.
